challenge_rx: RTL and testbench

UART receive stage for the PUF challenge path. Deserialises 8N1 bytes from the external `rxd` pin, assembles 16 consecutive bytes into one 128-bit challenge and hands it to the PUF core over a valid/ready handshake. Sits between the `rxd` pin of `Top` and the PUF challenge input; its transmit-side counterpart serialises the response onto `txd`.

---
 rtl/puf_pkg.sv | 15 +
 rtl/uart_rx_byte.sv | 96 +++++++++
 rtl/challenge_rx.sv | 88 ++++++++
 tb/tb_challenge_rx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Constants and types shared by the PUF UART challenge (RX) and response (TX) stages.
package puf_pkg;

  localparam int CHAL_W               = 128;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rxd synchroniser, bit FSM and baud counter.
// byte_valid / frame_err are single-cycle strobes in the cycle that precedes the stop-sample edge.
module uart_rx_byte
  import puf_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic           meta_reg, rxs_reg;
  uart_rx_state_t state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [2:0]     bit_reg, bit_next;
  logic [7:0]     data_reg, data_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg  <= 1'b1;
      rxs_reg   <= 1'b1;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      data_reg  <= '0;
    end else begin
      meta_reg  <= rxd;
      rxs_reg   <= meta_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    bit_next   = bit_reg;
    data_next  = data_reg;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (state_reg)
      // The cycle that detects the falling edge already counts toward the half-bit wait.
      IDLE: begin
        cnt_next = rxs_reg ? '0 : CW'(1);
        if (!rxs_reg) state_next = START;
      end
      START: begin
        if (cnt_reg == HALF_M1) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rxs_reg ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next  = '0;
          data_next = {rxs_reg, data_reg[7:1]};
          bit_next  = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next = '0;
          if (rxs_reg) begin
            byte_valid = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_next = '0;
        if (rxs_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign byte_data = data_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: rtl/challenge_rx.sv
// UART challenge receiver: gathers CHAL_BYTES good bytes (first byte ends up in the MSBs)
// and offers the assembled challenge to the PUF core over valid/ready.
module challenge_rx
  import puf_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CHAL_BYTES   = CHAL_W / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rxd,
  output logic [8*CHAL_BYTES-1:0] challenge,
  output logic                    chal_valid,
  input  logic                    chal_ready,
  output logic                    frame_err,
  output logic                    overrun,
  output logic                    busy
);

  localparam int             W    = 8 * CHAL_BYTES;
  localparam int             BCW  = (CHAL_BYTES > 1) ? $clog2(CHAL_BYTES) : 1;
  localparam logic [BCW-1:0] LAST = BCW'(CHAL_BYTES - 1);

  logic [7:0]     byte_data;
  logic           byte_valid, byte_ferr;
  logic [W-1:0]   sr_reg, sr_shift, challenge_reg;
  logic [BCW-1:0] bcnt_reg;
  logic           chal_valid_reg, frame_err_reg, overrun_reg;
  logic           xfer;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (byte_ferr),
    .busy       (busy)
  );

  generate
    if (CHAL_BYTES > 1) begin : g_shift
      assign sr_shift = {sr_reg[W-9:0], byte_data};
    end else begin : g_single
      assign sr_shift = byte_data;
    end
  endgenerate

  assign xfer = chal_valid_reg & chal_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg         <= '0;
      bcnt_reg       <= '0;
      challenge_reg  <= '0;
      chal_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      frame_err_reg <= byte_ferr;
      overrun_reg   <= 1'b0;
      if (xfer) chal_valid_reg <= 1'b0;
      if (byte_ferr) begin
        bcnt_reg <= '0;
      end else if (byte_valid) begin
        sr_reg <= sr_shift;
        if (bcnt_reg == LAST) begin
          bcnt_reg <= '0;
          // A transfer on this same edge frees the output register for the new challenge.
          if (!chal_valid_reg || xfer) begin
            challenge_reg  <= sr_shift;
            chal_valid_reg <= 1'b1;
          end else begin
            overrun_reg <= 1'b1;
          end
        end else begin
          bcnt_reg <= bcnt_reg + BCW'(1);
        end
      end
    end
  end

  assign challenge  = challenge_reg;
  assign chal_valid = chal_valid_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_challenge_rx.sv
// Self-checking bench for challenge_rx: table of whole-frame vectors, hand-timed corner
// sequences, and a randomized run against a byte-queue reference model.
module tb_challenge_rx;
  import puf_pkg::*;

  localparam int C = 16;
  localparam logic [127:0] CASE1 = 128'h2d95031a235ae849a6e2668f5f906753;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rxd = 1'b1;
  logic              chal_ready = 1'b0;
  logic [CHAL_W-1:0] challenge;
  logic              chal_valid, frame_err, overrun, busy;

  challenge_rx #(.CLKS_PER_BIT(C), .CHAL_BYTES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .challenge  (challenge),
    .chal_valid (chal_valid),
    .chal_ready (chal_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_pass = 0;
  int           ferr_cnt = 0;
  int           ovr_cnt = 0;
  int           valid_cycles = 0;
  int           busy_cycles = 0;
  logic [127:0] xfer_q[$];

  // Observe the DUT on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (chal_valid) valid_cycles++;
      if (busy) busy_cycles++;
      if (chal_valid && chal_ready) xfer_q.push_back(challenge);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  function automatic logic [127:0] xfer_at(input int idx);
    if (idx < xfer_q.size()) return xfer_q[idx];
    return 'x;
  endfunction

  function automatic logic [127:0] pack(input logic [7:0] q[$]);
    logic [127:0] v = '0;
    for (int i = 0; i < q.size(); i++) v = v | (128'(q[i]) << (8 * (15 - i)));
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit ready_at_stop);
    rxd = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(C);
    end
    rxd = stop_ok;
    // The stop sample lands 10 clocks into the stop bit (2 sync + 8 half-bit).
    if (ready_at_stop) begin
      tick(9);
      chal_ready = 1'b1;
      tick(C - 9);
    end else begin
      tick(C);
    end
    rxd = 1'b1;
    tick(4);
  endtask

  task automatic send_frame(input logic [127:0] v, input bit ready_last);
    for (int i = 0; i < 16; i++) send_byte(v[127-8*i -: 8], 1'b1, ready_last && (i == 15));
  endtask

  typedef struct {
    int           n_prefix;
    bit           bad;
    logic [127:0] data;
    logic [127:0] exp;
    int           exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int           base, f0, o0, v0, b0, nferr;
    logic [127:0] a, b;
    logic [7:0]   good_q[$];
    logic [127:0] exp_q[$];

    vecs[0] = '{0, 1'b0, CASE1, 128'h2d95031a235ae849a6e2668f5f906753, 0};
    vecs[1] = '{5, 1'b1, CASE1, 128'h2d95031a235ae849a6e2668f5f906753, 1};
    vecs[2] = '{0, 1'b0, 128'h0, 128'h0, 0};
    vecs[3] = '{0, 1'b0, {16{8'hff}}, 128'hffffffffffffffffffffffffffffffff, 0};
    vecs[4] = '{3, 1'b1, 128'h0123456789abcdeffedcba9876543210,
                128'h0123456789abcdeffedcba9876543210, 1};

    // Reset state
    tick(3);
    check("rst_challenge", challenge, '0);
    check("rst_valid", 128'(chal_valid), 0);
    check("rst_frame_err", 128'(frame_err), 0);
    check("rst_overrun", 128'(overrun), 0);
    check("rst_busy", 128'(busy), 0);
    rst = 1'b0;
    tick(4);

    // Table: optional good prefix, optional bad-stop 0xA5, then a full frame with ready high.
    chal_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      base = xfer_q.size(); f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles;
      for (int p = 0; p < vecs[k].n_prefix; p++) send_byte(8'($urandom), 1'b1, 1'b0);
      if (vecs[k].bad) send_byte(8'ha5, 1'b0, 1'b0);
      send_frame(vecs[k].data, 1'b0);
      tick(4);
      $display("vec %0d: prefix=%0d bad=%0d data=%h", k, vecs[k].n_prefix, vecs[k].bad, vecs[k].data);
      check($sformatf("vec%0d_nxfer", k), 128'(xfer_q.size() - base), 1);
      check($sformatf("vec%0d_chal", k), xfer_at(base), vecs[k].exp);
      check($sformatf("vec%0d_ferr", k), 128'(ferr_cnt - f0), 128'(vecs[k].exp_ferr));
      check($sformatf("vec%0d_ovr", k), 128'(ovr_cnt - o0), 0);
      check($sformatf("vec%0d_vcyc", k), 128'(valid_cycles - v0), 1);
    end

    // Start-bit glitch: no byte, no error, busy returns low.
    base = xfer_q.size(); f0 = ferr_cnt; b0 = busy_cycles;
    rxd = 1'b0; tick(4); rxd = 1'b1; tick(30);
    $display("glitch: 4-cycle low pulse");
    check("glitch_busy_seen", 128'(busy_cycles - b0 > 0), 1);
    check("glitch_busy_end", 128'(busy), 0);
    check("glitch_ferr", 128'(ferr_cnt - f0), 0);
    send_frame(CASE1, 1'b0);
    tick(4);
    check("glitch_next_chal", xfer_at(base), CASE1);

    // Overrun: two frames with ready low, then release.
    chal_ready = 1'b0;
    base = xfer_q.size(); o0 = ovr_cnt;
    send_frame(CASE1, 1'b0);
    send_frame({16{8'hff}}, 1'b0);
    tick(4);
    $display("overrun: two frames held");
    check("ovr_valid", 128'(chal_valid), 1);
    check("ovr_challenge", challenge, CASE1);
    check("ovr_count", 128'(ovr_cnt - o0), 1);
    check("ovr_no_xfer", 128'(xfer_q.size() - base), 0);
    chal_ready = 1'b1;
    tick(1);
    check("ovr_xfer_val", xfer_at(base), CASE1);
    check("ovr_valid_drop", 128'(chal_valid), 0);

    // Reset during data bit 4 of byte 7.
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    b = 128'($urandom);
    rxd = 1'b0; tick(C);
    for (int i = 0; i < 4; i++) begin rxd = b[i]; tick(C); end
    rxd = b[4]; tick(8);
    rst = 1'b1; rxd = 1'b1;
    tick(3);
    $display("midreset: reset in byte 7 bit 4");
    check("mrst_challenge", challenge, '0);
    check("mrst_valid", 128'(chal_valid), 0);
    check("mrst_busy", 128'(busy), 0);
    check("mrst_ferr", 128'(frame_err), 0);
    check("mrst_ovr", 128'(overrun), 0);
    rst = 1'b0;
    tick(4);
    base = xfer_q.size();
    a = {$urandom, $urandom, $urandom, $urandom};
    send_frame(a, 1'b0);
    tick(4);
    check("mrst_nxfer", 128'(xfer_q.size() - base), 1);
    check("mrst_chal", xfer_at(base), a);

    // Ready rises on the very edge that challenge B completes.
    chal_ready = 1'b0;
    base = xfer_q.size(); o0 = ovr_cnt;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    send_frame(a, 1'b0);
    send_frame(b, 1'b1);
    tick(4);
    $display("sameedge: A=%h B=%h", a, b);
    check("same_nxfer", 128'(xfer_q.size() - base), 2);
    check("same_xfer_a", xfer_at(base), a);
    check("same_xfer_b", xfer_at(base + 1), b);
    check("same_no_ovr", 128'(ovr_cnt - o0), 0);

    // Randomized bytes with occasional framing errors vs. byte-queue model.
    chal_ready = 1'b1;
    base = xfer_q.size(); f0 = ferr_cnt; nferr = 0;
    while (exp_q.size() < 2) begin
      logic [7:0] rb;
      bit         bad;
      rb  = 8'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      send_byte(rb, !bad, 1'b0);
      if (bad) begin
        nferr++;
        good_q.delete();
      end else begin
        good_q.push_back(rb);
        if (good_q.size() == 16) begin
          exp_q.push_back(pack(good_q));
          good_q.delete();
        end
      end
    end
    tick(4);
    $display("random: %0d frames, %0d framing errors injected", exp_q.size(), nferr);
    check("rand_nxfer", 128'(xfer_q.size() - base), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rand_chal%0d", i), xfer_at(base + i), exp_q[i]);
    check("rand_ferr", 128'(ferr_cnt - f0), 128'(nferr));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
